// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and state type for the ALU sequencing controller
package alu_pkg;
    localparam int WIDTH = 16;
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_XOR = 3'b010;
    localparam logic [2:0] FN_ADD = 3'b011;
    localparam logic [2:0] FN_SUB = 3'b100;
    localparam logic [2:0] FN_SLT = 3'b101;
    localparam logic [2:0] FN_SLL = 3'b110;
    localparam logic [2:0] FN_CMP = 3'b111;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_flamujt.sv
// alu_flamujt: combinational Z/C/V/N generator from the ALU adder outputs
module alu_flamujt
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    input  logic [2:0]       funct_i,
    output logic             z_o,
    output logic             c_o,
    output logic             v_o,
    output logic             n_o
);
    logic v_raw, arith, slt;
    // SLT reports Z/N of its 0/1 result; logic ops and SLL never overflow
    always_comb begin
        v_raw = (a_msb_i == b_msb_i) & (sum_i[WIDTH-1] != a_msb_i);
        arith = funct_i inside {FN_ADD, FN_SUB, FN_SLT, FN_CMP};
        slt   = funct_i == FN_SLT;
        v_o   = arith ? v_raw : 1'b0;
        c_o   = carry_i;
        n_o   = slt ? 1'b0 : sum_i[WIDTH-1];
        z_o   = slt ? ~(sum_i[WIDTH-1] ^ v_raw) : (sum_i == '0);
    end
endmodule

// File: rtl/alu_kontrolli.sv
// alu_kontrolli: sequencing controller for the 16-slice ALU; SLL support needs ALU_SHIFT_EN
module alu_kontrolli
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
`ifdef ALU_SHIFT_EN
    ,
    parameter int SHCNT_W = 4
`endif
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Funct,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [2:0]       AluOp,
    output logic             AluBInvert,
    output logic             AluCin,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluCarryOut,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             WriteEn,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
);
    state_t state_q, state_d;
    logic [2:0] funct_q, funct_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic we_q, we_d, sub_op, z, c, v, n;
    logic [WIDTH-1:0] b_eff;
`ifdef ALU_SHIFT_EN
    logic [SHCNT_W-1:0] cnt_q, cnt_d;
`endif

    assign sub_op = funct_q[2] & (funct_q != FN_SLL);
    assign b_eff = AluBInvert ? ~AluB : AluB;
    assign InReady = state_q == IDLE;
    assign OutValid = state_q == DONE;
    assign Result = result_q;
    assign WriteEn = we_q;
    assign {Zero, Carry, Overflow, Negative} = flags_q;

    // ALU control lines; SUB/SLT/CMP become A + ~B + 1, the shifter doubles a_q
    always_comb begin
        AluA = '0;
        AluB = '0;
        AluOp = OP_AND;
        AluBInvert = 1'b0;
        AluCin = 1'b0;
        if (state_q == EXEC) begin
            AluA = a_q;
            AluB = b_q;
            AluOp = funct_q[2] ? OP_ADD : funct_q;
            AluBInvert = sub_op;
            AluCin = sub_op;
        end
`ifdef ALU_SHIFT_EN
        if (state_q == SHIFT) begin
            AluA = a_q;
            AluB = a_q;
            AluOp = OP_ADD;
        end
`endif
    end

    alu_flamujt #(.WIDTH(WIDTH)) u_flags (
        .a_msb_i(AluA[WIDTH-1]),
        .b_msb_i(b_eff[WIDTH-1]),
        .sum_i(AluResult),
        .carry_i(AluCarryOut),
        .funct_i(funct_q),
        .z_o(z),
        .c_o(c),
        .v_o(v),
        .n_o(n)
    );

    // next state; a_q doubles as the shift accumulator
    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        a_d = a_q;
        b_d = b_q;
        result_d = result_q;
        flags_d = flags_q;
        we_d = we_q;
`ifdef ALU_SHIFT_EN
        cnt_d = cnt_q;
`endif
        case (state_q)
            IDLE: if (InValid) begin
                funct_d = Funct;
                a_d = OpA;
                b_d = OpB;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = DONE;
                result_d = (funct_q == FN_SLT) ? {{(WIDTH-1){1'b0}}, AluResult[WIDTH-1] ^ v} : AluResult;
                flags_d = {z, c, v, n};
                we_d = funct_q != FN_CMP;
                if (funct_q == FN_SLL) begin
`ifdef ALU_SHIFT_EN
                    result_d = a_q;
                    flags_d = {a_q == '0, 2'b00, a_q[WIDTH-1]};
                    we_d = 1'b1;
                    cnt_d = b_q[SHCNT_W-1:0];
                    if (b_q[SHCNT_W-1:0] != '0) state_d = SHIFT;
`else
                    result_d = '0;
                    flags_d = '0;
                    we_d = 1'b0;
`endif
                end
            end
`ifdef ALU_SHIFT_EN
            SHIFT: begin
                a_d = AluResult;
                cnt_d = cnt_q - SHCNT_W'(1);
                result_d = AluResult;
                flags_d = {z, c, v, n};
                we_d = 1'b1;
                if (cnt_q == SHCNT_W'(1)) state_d = DONE;
            end
`endif
            DONE: if (OutReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            funct_q <= '0;
            a_q <= '0;
            b_q <= '0;
            result_q <= '0;
            flags_q <= '0;
            we_q <= 1'b0;
`ifdef ALU_SHIFT_EN
            cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            a_q <= a_d;
            b_q <= b_d;
            result_q <= result_d;
            flags_q <= flags_d;
            we_q <= we_d;
`ifdef ALU_SHIFT_EN
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_kontrolli.sv
// tb_alu_kontrolli: random and directed checks of alu_kontrolli against a behavioural model
module tb_alu_kontrolli;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [2:0] funct, alu_op;
    logic [15:0] op_a, op_b, alu_a, alu_b, alu_res, result;
    logic alu_binv, alu_cin, alu_co, write_en, zf, cf, vf, nf;
    logic [15:0] bx;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // external ALU: slices share one adder chain feeding the result mux
    always_comb begin
        bx = alu_binv ? ~alu_b : alu_b;
        {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, bx} + {16'b0, alu_cin};
        if (alu_op == 3'd0) alu_res = alu_a & bx;
        else if (alu_op == 3'd1) alu_res = alu_a | bx;
        else if (alu_op == 3'd2) alu_res = alu_a ^ bx;
    end

    alu_kontrolli dut (
        .Clock(clk), .ResetN(rst_n), .InValid(in_valid), .InReady(in_ready),
        .Funct(funct), .OpA(op_a), .OpB(op_b),
        .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluBInvert(alu_binv), .AluCin(alu_cin),
        .AluResult(alu_res), .AluCarryOut(alu_co),
        .OutValid(out_valid), .OutReady(out_ready), .Result(result), .WriteEn(write_en),
        .Zero(zf), .Carry(cf), .Overflow(vf), .Negative(nf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected outcome from the arithmetic meaning of each operation
    task automatic model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] fl, output logic we, output int lat);
        int sa, sb, s;
        int unsigned ua, ub;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {16'b0, a};
        ub = {16'b0, b};
        c = (ua + ub) > 65535;
        v = 1'b0;
        we = 1'b1;
        lat = 2;
        r = 16'h0;
        case (f)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: begin
                s = sa + sb;
                r = a + b;
                v = s > 32767 || s < -32768;
            end
            3'd6: begin
`ifdef ALU_SHIFT_EN
                r = a << b[3:0];
                c = b[3:0] == 0 ? 1'b0 : a[16 - int'(b[3:0])];
                lat = 2 + int'(b[3:0]);
`else
                we = 1'b0;
`endif
            end
            default: begin
                s = sa - sb;
                c = ua >= ub;
                v = s > 32767 || s < -32768;
                r = (f == 3'd5) ? ((sa < sb) ? 16'd1 : 16'd0) : a - b;
                we = f != 3'd7;
            end
        endcase
        fl = {r == 16'h0, c, v, r[15]};
`ifndef ALU_SHIFT_EN
        if (f == 3'd6) fl = 4'b0;
`endif
    endtask

    task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] er;
        logic [3:0] ef;
        logic ew;
        int lat, edges;
        logic subl;
        model(f, a, b, er, ef, ew, lat);
        subl = f == 3'd4 || f == 3'd5 || f == 3'd7;
        @(negedge clk);
        check("in_ready_before", in_ready, 1);
        in_valid = 1'b1;
        funct = f;
        op_a = a;
        op_b = b;
        out_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check("exec_binv", alu_binv, subl);
        check("exec_cin", alu_cin, subl);
        if (f != 3'd6) check("exec_aluop", alu_op, f[2] ? 3'd3 : f);
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, lat);
        check("result", result, er);
        check("write_en", write_en, ew);
        check("flags_zcvn", {zf, cf, vf, nf}, ef);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            funct = 3'd3;
            op_a = 16'(~a);
            op_b = 16'(~b);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, er);
            check("hold_flags", {zf, cf, vf, nf}, ef);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        funct = 3'd0;
        op_a = 16'h0;
        op_b = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_write_en", write_en, 0);
        check("rst_flags", {zf, cf, vf, nf}, 0);
        check("rst_alu_ab", {alu_a, alu_b}, 0);
        check("rst_alu_ctrl", {alu_op, alu_binv, alu_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run_op(3'd3, 16'h7FFF, 16'h0001, 0);
        run_op(3'd4, 16'h0005, 16'h0005, 0);
        run_op(3'd5, 16'hFFFE, 16'h0001, 0);
        run_op(3'd7, 16'h0003, 16'h0009, 0);
        run_op(3'd6, 16'h8001, 16'h0003, 0);
        run_op(3'd6, 16'h8001, 16'h0000, 0);
        run_op(3'd6, 16'h0001, 16'h000F, 0);
        run_op(3'd3, 16'hFFFF, 16'h0001, 0);
        run_op(3'd5, 16'h8000, 16'h7FFF, 0);
        run_op(3'd4, 16'h8000, 16'h0001, 4);
        run_op(3'd0, 16'hF0F0, 16'hFF00, 0);
        run_op(3'd1, 16'hF0F0, 16'h0F00, 0);
        run_op(3'd2, 16'hAAAA, 16'hAAAA, 0);

        for (int k = 0; k < 150; k++)
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));

        // reset asserted mid-operation must take effect without a clock edge
        @(negedge clk);
        in_valid = 1'b1;
        funct = 3'd6;
        op_a = 16'h1234;
        op_b = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef ALU_SHIFT_EN
        @(posedge clk);
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd3, 16'h1234, 16'h4321, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
